// File: rtl/divider_seq.sv
// divider_seq: sequential restoring divider, DIVIDEND_W-bit dividend by
// DIVISOR_W-bit divisor, one quotient bit per clock, start/done handshake.
// Optional feature macro: DIV_ZERO_CHECK_EN (1-cycle divide-by-zero path
// with a registered div_by_zero flag). When undefined, a zero divisor runs
// through the normal algorithm and div_by_zero is tied low.
module divider_seq #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [DIVIDEND_W-1:0] dvd_r, dvd_nxt_s;        // dividend, shifted MSB-first
  logic [DIVISOR_W-1:0]  dvs_r, dvs_nxt_s;        // captured divisor
  logic [DIVISOR_W-1:0]  rem_r, rem_nxt_s;        // partial remainder R
  logic [DIVIDEND_W-1:0] quo_r, quo_nxt_s;        // quotient being assembled
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;        // CALC iteration counter
  logic [DIVIDEND_W-1:0] quotient_r, quotient_nxt_s;
  logic [DIVISOR_W-1:0]  remainder_r, remainder_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  done_r, done_nxt_s;

  // One restoring step: trial value, compare, and the two candidate remainders.
  logic [DIVISOR_W:0]    trial_s;
  logic                  fits_s;
  logic [DIVISOR_W-1:0]  diff_s;
  logic [DIVISOR_W-1:0]  rem_step_s;
  logic [DIVIDEND_W-1:0] quo_step_s;

  assign trial_s    = {rem_r, dvd_r[DIVIDEND_W-1]};
  assign fits_s     = (trial_s >= {1'b0, dvs_r});
  // Only the low bits of T - divisor survive: the difference is < divisor.
  assign diff_s     = trial_s[DIVISOR_W-1:0] - dvs_r;
  assign rem_step_s = fits_s ? diff_s : trial_s[DIVISOR_W-1:0];
  assign quo_step_s = {quo_r[DIVIDEND_W-2:0], fits_s};

`ifdef DIV_ZERO_CHECK_EN
  logic dbz_r, dbz_nxt_s;
`endif

  // State register with asynchronous abort on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and registered output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_r       <= {DIVIDEND_W{1'b0}};
      dvs_r       <= {DIVISOR_W{1'b0}};
      rem_r       <= {DIVISOR_W{1'b0}};
      quo_r       <= {DIVIDEND_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      quotient_r  <= {DIVIDEND_W{1'b0}};
      remainder_r <= {DIVISOR_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      dbz_r       <= 1'b0;
`endif
    end else begin
      dvd_r       <= dvd_nxt_s;
      dvs_r       <= dvs_nxt_s;
      rem_r       <= rem_nxt_s;
      quo_r       <= quo_nxt_s;
      cnt_r       <= cnt_nxt_s;
      quotient_r  <= quotient_nxt_s;
      remainder_r <= remainder_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
`ifdef DIV_ZERO_CHECK_EN
      dbz_r       <= dbz_nxt_s;
`endif
    end
  end

  // Next-state and next-register values for every state.
  always_comb begin
    state_nxt_s     = state_r;
    dvd_nxt_s       = dvd_r;
    dvs_nxt_s       = dvs_r;
    rem_nxt_s       = rem_r;
    quo_nxt_s       = quo_r;
    cnt_nxt_s       = cnt_r;
    quotient_nxt_s  = quotient_r;
    remainder_nxt_s = remainder_r;
    busy_nxt_s      = busy_r;
    done_nxt_s      = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
    dbz_nxt_s       = dbz_r;
`endif

    case (state_r)
      IDLE: begin
        if (start) begin
          dvd_nxt_s  = dividend;
          dvs_nxt_s  = divisor;
          rem_nxt_s  = {DIVISOR_W{1'b0}};
          quo_nxt_s  = {DIVIDEND_W{1'b0}};
          cnt_nxt_s  = {CNT_W{1'b0}};
          busy_nxt_s = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
          if (divisor == {DIVISOR_W{1'b0}}) begin
            state_nxt_s = ZERO;
          end else begin
            state_nxt_s = CALC;
          end
`else
          state_nxt_s = CALC;
`endif
        end else begin
          busy_nxt_s = 1'b0;
        end
      end

      CALC: begin
        dvd_nxt_s = {dvd_r[DIVIDEND_W-2:0], 1'b0};
        rem_nxt_s = rem_step_s;
        quo_nxt_s = quo_step_s;
        cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_r == LAST_CNT) begin
          quotient_nxt_s  = quo_step_s;
          remainder_nxt_s = rem_step_s;
          done_nxt_s      = 1'b1;
          busy_nxt_s      = 1'b0;
          state_nxt_s     = IDLE;
`ifdef DIV_ZERO_CHECK_EN
          dbz_nxt_s       = 1'b0;
`endif
        end else begin
          busy_nxt_s = 1'b1;
        end
      end

`ifdef DIV_ZERO_CHECK_EN
      ZERO: begin
        quotient_nxt_s  = {DIVIDEND_W{1'b1}};
        remainder_nxt_s = dvd_r[DIVISOR_W-1:0];
        dbz_nxt_s       = 1'b1;
        done_nxt_s      = 1'b1;
        busy_nxt_s      = 1'b0;
        state_nxt_s     = IDLE;
      end
`endif

      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign busy      = busy_r;
  assign done      = done_r;
`ifdef DIV_ZERO_CHECK_EN
  assign div_by_zero = dbz_r;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: the driver pushes expected results
// computed with plain / and % into a queue, a monitor pops on every done.
module tb_divider_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [3:0] divisor = 4'd0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy, done, div_by_zero;

  divider_seq #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: quotient/remainder from ordinary integer division.
  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b, input int issue);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 4'd0) begin
      e.q = 8'hFF;
      e.r = a[3:0];
      e.z = ZCHK;
      e.due = issue + (ZCHK ? 1 : 8);
    end else begin
      e.q = 8'(int'(a) / int'(b));
      e.r = 4'(int'(a) % int'(b));
      e.z = 1'b0;
      e.due = issue + 8;
    end
    return e;
  endfunction

  // Monitor: compare every completion against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
        chk("latency_cycle", 32'(cyc), 32'(e.due));
        chk("busy_low_at_done", 32'(busy), 32'd0);
        if (e.b != 4'd0) begin
          chk("invariant", 32'(int'(quotient) * int'(e.b) + int'(remainder)), 32'(e.a));
          chk("rem_lt_div", 32'(remainder < e.b), 32'd1);
        end
      end
    end
  end

  // Wait (bounded) for IDLE, then issue one start pulse and push its expectation.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int bcnt;
    // Reset state (asynchronous reset held from time 0).
    #1;
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic division with busy-width check: 200/7 -> 28 r 4.
    run_op(8'd200, 4'd7);
    bcnt = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) bcnt++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(bcnt), 32'd8);
    chk("basic_q_const", 32'(quotient), 32'd28);
    chk("basic_r_const", 32'(remainder), 32'd4);
    drain();

    // Multiplier-inverse pairs and divide by zero.
    run_op(8'd255, 4'd15);
    drain();
    chk("inv_q_const", 32'(quotient), 32'd17);
    chk("inv_r_const", 32'(remainder), 32'd0);
    run_op(8'd9, 4'd10);
    run_op(8'hA6, 4'd0);
    drain();
    chk("dz_q_const", 32'(quotient), 32'hFF);
    chk("dz_r_const", 32'(remainder), 32'h6);

    // Start while busy is ignored; outputs hold while the op runs.
    run_op(8'd200, 4'd7);
    repeat (2) @(negedge clk);
    dividend = 8'd13;
    divisor  = 4'd2;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    chk("hold_during_op", 32'(quotient), 32'hFF);
    drain();

    // Back-to-back: second start lands in the done cycle.
    run_op(8'd50, 4'd6);
    run_op(8'd100, 4'd3);
    drain();
    chk("b2b_q_const", 32'(quotient), 32'd33);
    chk("b2b_r_const", 32'(remainder), 32'd1);

    // Asynchronous reset in the middle of CALC cycle 4.
    run_op(8'd200, 4'd7);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    chk("mid_rst_quotient", 32'(quotient), 32'd0);
    chk("mid_rst_remainder", 32'(remainder), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle_done", 32'(done), 32'd0);
    run_op(8'd77, 4'd5);
    drain();
    chk("post_rst_q_const", 32'(quotient), 32'd15);
    chk("post_rst_r_const", 32'(remainder), 32'd2);

    // Random operands (including zero divisors) with random gaps and stray starts.
    for (int i = 0; i < 200; i++) begin
      run_op(8'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        dividend = 8'($urandom);
        divisor  = 4'($urandom_range(1, 15));
        start    = busy;
        @(negedge clk);
        start    = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Exhaustive sweep of nonzero divisors, back-to-back.
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(8'(a), 4'(b));
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
